bit_reverse_loader: RTL and testbench

BIT_REVERSE_LOADER -- requirements
Module: bit_reverse_loader

---
 rtl/ntt_pkg.sv | 33 +++
 rtl/bitrev_index.sv | 15 +
 rtl/bit_reverse_loader.sv | 124 ++++++++++++
 tb/tb_bit_reverse_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT definitions: codebase default sizes, loader FSM states and the
// index bit-reversal helper.
package ntt_pkg;

    localparam int DEFAULT_RING_SIZE = 256;
    localparam int DEFAULT_DATA_W    = 32;
    localparam int MAX_IDX_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    // Reverses the low 'width' bits of value; bits above 'width' come back zero.
    function automatic logic [MAX_IDX_W-1:0] bit_reverse(
        input logic [MAX_IDX_W-1:0] value,
        input int                   width
    );
        logic [MAX_IDX_W-1:0] result;
        logic [MAX_IDX_W-1:0] rest;
        result = '0;
        rest   = value;
        for (int i = 0; i < MAX_IDX_W; i++) begin
            if (i < width) begin
                result = {result[MAX_IDX_W-2:0], rest[0]};
                rest   = rest >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bitrev_index.sv
// Maps a transfer count to a ring index: bit-reversed when mode=1, natural
// order when mode=0. Purely combinational.
module bitrev_index
    import ntt_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic [IDX_W-1:0] count,
    input  logic             mode,
    output logic [IDX_W-1:0] idx
);

    assign idx = mode ? IDX_W'(bit_reverse(MAX_IDX_W'(count), IDX_W)) : count;

endmodule

// File: rtl/bit_reverse_loader.sv
// Streams one frame of coefficients into NUM_BANKS RAM banks, writing each to
// its natural or bit-reversed ring position with one cycle of write latency.
module bit_reverse_loader
    import ntt_pkg::*;
#(
    parameter int  RING_SIZE = DEFAULT_RING_SIZE,
    parameter int  DATA_W    = DEFAULT_DATA_W,
    parameter int  NUM_BANKS = 2,
    localparam int IDX_W     = $clog2(RING_SIZE),
    localparam int LOG2_NB   = $clog2(NUM_BANKS),
    localparam int BSEL_W    = (NUM_BANKS == 1) ? 1 : LOG2_NB,
    localparam int ADDR_W    = IDX_W - LOG2_NB
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    din,
    output logic [NUM_BANKS-1:0] bank_we,
    output logic [ADDR_W-1:0]    bank_addr,
    output logic [DATA_W-1:0]    bank_data,
    output logic                 busy,
    output logic                 done
);

    load_state_t          state_reg;
    load_state_t          state_next;
    logic [IDX_W:0]       count_reg;
    logic [IDX_W:0]       count_next;
    logic                 mode_reg;
    logic                 mode_next;
    logic                 transfer;
    logic                 last_xfer;
    logic [IDX_W-1:0]     idx;
    logic [BSEL_W-1:0]    bank_sel;
    logic [NUM_BANKS-1:0] we_next;
    logic [ADDR_W-1:0]    addr_next;

    bitrev_index #(
        .IDX_W (IDX_W)
    ) u_bitrev_index (
        .count (count_reg[IDX_W-1:0]),
        .mode  (mode_reg),
        .idx   (idx)
    );

    assign transfer  = in_valid && in_ready;
    assign last_xfer = (count_reg == (IDX_W+1)'(RING_SIZE - 1));

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        mode_next  = mode_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                    mode_next  = mode;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (transfer) begin
                    count_next = count_reg + 1'b1;
                    if (last_xfer) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                    mode_next  = mode;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The top index bits pick the bank, the remaining low bits address within it.
    if (NUM_BANKS == 1) begin : g_single_bank
        assign bank_sel = '0;
    end else begin : g_multi_bank
        assign bank_sel = idx[IDX_W-1 -: LOG2_NB];
    end

    assign addr_next = idx[ADDR_W-1:0];

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_we
        assign we_next[gi] = transfer && (bank_sel == BSEL_W'(gi));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            mode_reg  <= 1'b1;
            bank_we   <= '0;
            bank_addr <= '0;
            bank_data <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            mode_reg  <= mode_next;
            bank_we   <= we_next;
            if (transfer) begin
                bank_addr <= addr_next;
                bank_data <= din;
            end
        end
    end

endmodule

// File: tb/tb_bit_reverse_loader.sv
// Self-checking bench: table vectors for the 8-entry/2-bank loader, random
// valid gaps, reset and start corner cases, and a 16-entry/4-bank frame.
module tb_bit_reverse_loader;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        a_start, a_mode, a_in_valid;
    logic [15:0] a_din;
    logic        a_in_ready, a_busy, a_done;
    logic [1:0]  a_bank_we;
    logic [1:0]  a_bank_addr;
    logic [15:0] a_bank_data;

    logic        b_start, b_mode, b_in_valid;
    logic [15:0] b_din;
    logic        b_in_ready, b_busy, b_done;
    logic [3:0]  b_bank_we;
    logic [1:0]  b_bank_addr;
    logic [15:0] b_bank_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int a_last_addr = 0;
    int a_last_data = 0;

    always #5 clk = ~clk;

    bit_reverse_loader #(.RING_SIZE(8), .DATA_W(16), .NUM_BANKS(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din),
        .bank_we(a_bank_we), .bank_addr(a_bank_addr), .bank_data(a_bank_data),
        .busy(a_busy), .done(a_done)
    );

    bit_reverse_loader #(.RING_SIZE(16), .DATA_W(16), .NUM_BANKS(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
        .bank_we(b_bank_we), .bank_addr(b_bank_addr), .bank_data(b_bank_data),
        .busy(b_busy), .done(b_done)
    );

    typedef struct {
        bit mode;
        int k;
        int bank;
        int addr;
    } vec_t;

    vec_t tbl[16];

    // Reference: reverse 'w' bits of v by peeling off the low bit arithmetically.
    function automatic int rev_bits(input int v, input int w);
        int r = 0;
        int x = v;
        for (int i = 0; i < w; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic a_expect_write(input bit m, input int k, input int d);
        int idx;
        idx = m ? rev_bits(k, 3) : k;
        chk("a_we", int'(a_bank_we), 1 << (idx / 4));
        chk("a_addr", int'(a_bank_addr), idx % 4);
        chk("a_data", int'(a_bank_data), d);
        a_last_addr = idx % 4;
        a_last_data = d;
        $display("a xfer mode=%0d k=%0d -> bank %0d addr %0d data %0h",
                 m, k, idx / 4, idx % 4, d);
    endtask

    task automatic a_start_frame(input bit m);
        a_start    = 1'b1;
        a_mode     = m;
        a_in_valid = 1'b0;
        step();
        a_start = 1'b0;
        chk("a_busy_after_start", int'(a_busy), 1);
        chk("a_ready_after_start", int'(a_in_ready), 1);
        chk("a_done_after_start", int'(a_done), 0);
    endtask

    task automatic a_check_done();
        a_in_valid = 1'b0;
        step();
        chk("a_done", int'(a_done), 1);
        chk("a_ready_in_done", int'(a_in_ready), 0);
        chk("a_busy_in_done", int'(a_busy), 0);
        chk("a_we_in_done", int'(a_bank_we), 0);
    endtask

    task automatic a_full_frame(input bit m);
        int d;
        a_start_frame(m);
        for (int k = 0; k < 8; k++) begin
            d = int'($urandom_range(0, 65535));
            a_in_valid = 1'b1;
            a_din      = 16'(d);
            a_mode     = ~m;
            step();
            a_expect_write(m, k, d);
            if (k < 7) chk("a_done_early", int'(a_done), 0);
        end
        a_check_done();
    endtask

    initial begin
        int k;
        int d;
        int idx;

        tbl[0]  = '{1'b1, 0, 0, 0}; tbl[1]  = '{1'b1, 1, 1, 0};
        tbl[2]  = '{1'b1, 2, 0, 2}; tbl[3]  = '{1'b1, 3, 1, 2};
        tbl[4]  = '{1'b1, 4, 0, 1}; tbl[5]  = '{1'b1, 5, 1, 1};
        tbl[6]  = '{1'b1, 6, 0, 3}; tbl[7]  = '{1'b1, 7, 1, 3};
        tbl[8]  = '{1'b0, 0, 0, 0}; tbl[9]  = '{1'b0, 1, 0, 1};
        tbl[10] = '{1'b0, 2, 0, 2}; tbl[11] = '{1'b0, 3, 0, 3};
        tbl[12] = '{1'b0, 4, 1, 0}; tbl[13] = '{1'b0, 5, 1, 1};
        tbl[14] = '{1'b0, 6, 1, 2}; tbl[15] = '{1'b0, 7, 1, 3};

        reset_n = 1'b0;
        a_start = 1'b0; a_mode = 1'b0; a_in_valid = 1'b0; a_din = '0;
        b_start = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0; b_din = '0;
        #3;
        chk("rst_we", int'(a_bank_we), 0);
        chk("rst_addr", int'(a_bank_addr), 0);
        chk("rst_data", int'(a_bank_data), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_ready", int'(a_in_ready), 0);
        step();
        step();
        reset_n = 1'b1;
        a_in_valid = 1'b1;
        step();
        chk("idle_ignores_valid_we", int'(a_bank_we), 0);
        chk("idle_wait_busy", int'(a_busy), 0);

        // Scenarios 1 and 2 from the vector table
        for (int v = 0; v < 16; v++) begin
            if (tbl[v].k == 0) a_start_frame(tbl[v].mode);
            a_in_valid = 1'b1;
            a_din      = 16'(16'hA500 + v);
            step();
            chk("tbl_we", int'(a_bank_we), 1 << tbl[v].bank);
            chk("tbl_addr", int'(a_bank_addr), tbl[v].addr);
            chk("tbl_data", int'(a_bank_data), 16'hA500 + v);
            a_last_addr = tbl[v].addr;
            a_last_data = 16'hA500 + v;
            $display("tbl xfer mode=%0d k=%0d bank=%0d addr=%0d",
                     tbl[v].mode, tbl[v].k, tbl[v].bank, tbl[v].addr);
            if (tbl[v].k < 7) chk("tbl_done_early", int'(a_done), 0);
            if (tbl[v].k == 7) a_check_done();
        end

        // Scenario 3: random 50% valid, mode input wiggled after start
        a_start_frame(1'b1);
        k = 0;
        for (int c = 0; c < 200 && k < 8; c++) begin
            a_in_valid = 1'($urandom_range(0, 1));
            d          = int'($urandom_range(0, 65535));
            a_din      = 16'(d);
            a_mode     = 1'($urandom_range(0, 1));
            step();
            if (a_in_valid) begin
                a_expect_write(1'b1, k, d);
                k++;
            end else begin
                chk("gap_we", int'(a_bank_we), 0);
                chk("gap_addr_hold", int'(a_bank_addr), a_last_addr);
                chk("gap_data_hold", int'(a_bank_data), a_last_data);
            end
        end
        chk("rand_frame_complete", k, 8);
        a_check_done();

        // Scenario 4: reset after the third transfer
        a_start_frame(1'b1);
        for (int j = 0; j < 3; j++) begin
            a_in_valid = 1'b1;
            a_din      = 16'(16'h3300 + j);
            step();
            a_expect_write(1'b1, j, 16'h3300 + j);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_we", int'(a_bank_we), 0);
        chk("midrst_addr", int'(a_bank_addr), 0);
        chk("midrst_data", int'(a_bank_data), 0);
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_ready", int'(a_in_ready), 0);
        for (int j = 0; j < 2; j++) begin
            step();
            chk("inrst_we", int'(a_bank_we), 0);
        end
        reset_n = 1'b1;
        step();
        chk("postrst_we", int'(a_bank_we), 0);
        chk("postrst_busy", int'(a_busy), 0);
        a_last_addr = 0;
        a_last_data = 0;
        a_full_frame(1'b1);
        a_full_frame(1'b0);

        // Scenario 5: start during LOAD ignored, start in DONE restarts
        a_start_frame(1'b1);
        for (int j = 0; j < 8; j++) begin
            a_in_valid = 1'b1;
            a_din      = 16'(16'h5500 + j);
            a_start    = (j == 2);
            a_mode     = 1'b0;
            step();
            a_expect_write(1'b1, j, 16'h5500 + j);
            chk("load_start_busy", int'(a_busy), (j < 7) ? 1 : 0);
        end
        a_start = 1'b0;
        a_check_done();
        a_start = 1'b1;
        a_mode  = 1'b0;
        step();
        a_start = 1'b0;
        chk("restart_done_clear", int'(a_done), 0);
        chk("restart_busy", int'(a_busy), 1);
        a_in_valid = 1'b1;
        a_din      = 16'h7777;
        step();
        a_expect_write(1'b0, 0, 16'h7777);
        a_in_valid = 1'b0;

        // Scenario 6: 16 entries over 4 banks, bit-reversed
        b_start = 1'b1;
        b_mode  = 1'b1;
        step();
        b_start = 1'b0;
        chk("b_busy", int'(b_busy), 1);
        for (int j = 0; j < 16; j++) begin
            d          = int'($urandom_range(0, 65535));
            b_in_valid = 1'b1;
            b_din      = 16'(d);
            step();
            idx = rev_bits(j, 4);
            chk("b_we", int'(b_bank_we), 1 << (idx / 4));
            chk("b_addr", int'(b_bank_addr), idx % 4);
            chk("b_data", int'(b_bank_data), d);
            if (j == 1) begin
                chk("b_xfer1_we", int'(b_bank_we), 4);
                chk("b_xfer1_addr", int'(b_bank_addr), 0);
            end
            if (j == 3) begin
                chk("b_xfer3_we", int'(b_bank_we), 8);
                chk("b_xfer3_addr", int'(b_bank_addr), 0);
            end
            $display("b xfer k=%0d -> bank %0d addr %0d", j, idx / 4, idx % 4);
        end
        b_in_valid = 1'b0;
        step();
        chk("b_done", int'(b_done), 1);
        chk("b_we_after", int'(b_bank_we), 0);
        chk("b_ready_after", int'(b_in_ready), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
